// File: rtl/rr_arbiter8_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
// Imported by the interface, the picker and the top.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between requesters and rr_arbiter8.
// master drives req/done; slave (the arbiter) drives the grant side.
interface rr_arbiter8_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_valid;
  logic               timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output timeout
  );

endinterface

// File: rtl/rr_pick8.sv
// Rotating priority encoder: first set req bit at ptr, ptr+1, ... mod 8.
// Purely combinational.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  logic [ID_W-1:0] idx;

  // Scan from the far end so the closest-to-ptr hit wins last.
  always_comb begin
    id  = '0;
    any = 1'b0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + ID_W'(i);
      if (req[idx]) begin
        id  = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter, one idle cycle between grants.
// Define ARB_TIMEOUT_EN to build the MAX_HOLD forced release.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input logic           clk,
  input logic           rst_n,
  rr_arbiter8_if.slave  bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_hold
    $error("rr_arbiter8: MAX_HOLD must be 1..15");
  end

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
  logic                 gnt_valid_q, gnt_valid_d;
  logic                 timeout_q, timeout_d;

  logic [ID_W-1:0]      pick_id;
  logic                 pick_any;
  logic                 owner_req;
  logic                 expire;
  logic                 rel;

  rr_pick8 u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .id  (pick_id),
    .any (pick_any)
  );

  assign owner_req = bus.req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
  logic [3:0] hold_q, hold_d;

  assign expire = (hold_q == 4'(MAX_HOLD - 1));

  always_comb begin
    hold_d = hold_q;
    unique case (1'b1)
      (state_q == IDLE): hold_d = '0;
      (hold_q != 4'hF):  hold_d = hold_q + 4'd1;
      default:           hold_d = hold_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    rel         = bus.done | ~owner_req | expire;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (pick_any) begin
          state_d     = GRANT;
          gnt_d       = NUM_REQ'(1) << pick_id;
          gnt_id_d    = pick_id;
          gnt_valid_d = 1'b1;
        end
      end
      (state_q == GRANT): begin
        if (rel) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_id_q + ID_W'(1);
          // Only a pure expiry counts as a forced release.
          timeout_d   = expire & ~bus.done & owner_req;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule
